// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage, the decoder and the ALU.
package cpu_pkg;

  localparam int PC_W_DEF      = 10;
  localparam int LUT_IDX_W_DEF = 4;
  localparam int PC_RST        = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_CMP  = 4'd7,
    ALU_PASS = 4'd8
  } alu_op_t;

endpackage

// File: rtl/branch_lut.sv
// Branch/jump target table: async-cleared register file, one sync write, one comb read.
module branch_lut #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    mem_q <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read sees the pre-edge contents, so a same-edge write is only visible next cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter, carry flag and start/halt sequencing downstream of the ALU.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 jump_en,
  input  logic                 branch_en,
  input  logic                 branchFlag,
  input  logic [LUT_IDX_W-1:0] target_idx,
  input  logic                 carry_we,
  input  logic                 carry_in,
  output logic                 carry_q,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc,
  output logic                 busy,
  output logic                 done
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, lut_rdata;
  logic            carry_r, carry_d;
  logic            busy_q, busy_d, done_q, done_d;

  branch_lut #(.IDX_W(LUT_IDX_W), .DATA_W(PC_W)) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (lut_we),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata),
    .raddr_i (target_idx),
    .rdata_o (lut_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(PC_RST);
      carry_r <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      carry_r <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    carry_d = carry_r;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = PC_W'(PC_RST);
          carry_d = 1'b0;
        end
      end
      RUN: begin
        // Carry commits even on the HALT instruction itself.
        if (carry_we) carry_d = carry_in;
        if (halt_req)                              state_d = HALT;
        else if (jump_en || (branch_en && branchFlag)) pc_d = lut_rdata;
        else                                       pc_d = pc_q + PC_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == HALT);
  end

  assign pc      = pc_q;
  assign carry_q = carry_r;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
  import cpu_pkg::*;

  localparam int PC_W = 10;
  localparam int IW   = 4;

  logic            clk, rst_n, start, halt_req, jump_en, branch_en, branchFlag;
  logic [IW-1:0]   target_idx, lut_waddr;
  logic            carry_we, carry_in, carry_q, lut_we, busy, done;
  logic [PC_W-1:0] lut_wdata, pc;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(.PC_W(PC_W), .LUT_IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .jump_en(jump_en), .branch_en(branch_en), .branchFlag(branchFlag),
    .target_idx(target_idx), .carry_we(carry_we), .carry_in(carry_in),
    .carry_q(carry_q), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .pc(pc), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder must never request a carry write while the ALU carry is unknown.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && busy === 1'b1 && carry_we === 1'b1 && $isunknown(carry_in)) begin
      failures++;
      $error("FAIL carry_x: carry_we with carry_in=%b", carry_in);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [PC_W-1:0] epc,
                         input logic eb, input logic ed, input logic ec);
    chk({tag, ".pc"},    32'(pc),      32'(epc));
    chk({tag, ".busy"},  32'(busy),    32'(eb));
    chk({tag, ".done"},  32'(done),    32'(ed));
    chk({tag, ".carry"}, 32'(carry_q), 32'(ec));
  endtask

  task automatic lut_wr(input logic [IW-1:0] idx, input logic [PC_W-1:0] data);
    lut_we = 1'b1; lut_waddr = idx; lut_wdata = data;
    step();
    lut_we = 1'b0;
  endtask

  task automatic jump(input logic [IW-1:0] idx);
    jump_en = 1'b1; target_idx = idx;
    step();
    jump_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; halt_req = 0; jump_en = 0; branch_en = 0; branchFlag = 0;
    target_idx = '0; carry_we = 0; carry_in = 0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    #12;
    chk_all("reset", 10'h000, 0, 0, 0);
    rst_n = 1'b1;

    // Table loads in IDLE; control inputs asserted alongside must be ignored.
    halt_req = 1; jump_en = 1; carry_we = 1; carry_in = 1; target_idx = 4'd1;
    lut_wr(4'd1, 10'h010);
    halt_req = 0; jump_en = 0; carry_we = 0; carry_in = 0;
    chk_all("idle_ignore", 10'h000, 0, 0, 0);
    lut_wr(4'd2, 10'h100);
    lut_wr(4'd3, 10'h040);
    lut_wr(4'd4, 10'h020);
    lut_wr(4'd5, 10'h3FF);
    lut_wr(4'd6, 10'h055);

    start = 1; step(); start = 0;
    chk_all("start", 10'h000, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all($sformatf("seq%0d", i), PC_W'(i), 1, 0, 0);
    end

    carry_we = 1; carry_in = 1; step(); carry_we = 0; carry_in = 0;
    chk_all("carry_set", 10'h006, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("carry_hold%0d", i), 32'(carry_q), 32'd1);
    end

    jump(4'd1);
    chk("jump_010", 32'(pc), 32'h010);
    branch_en = 1; branchFlag = 1; target_idx = 4'd3; step();
    branch_en = 0; branchFlag = 0;
    chk("br_taken", 32'(pc), 32'h040);
    jump(4'd1);
    branch_en = 1; branchFlag = 0; target_idx = 4'd3; step();
    branch_en = 0;
    chk("br_not_taken", 32'(pc), 32'h011);

    jump(4'd4);
    halt_req = 1; jump_en = 1; branch_en = 1; branchFlag = 1; target_idx = 4'd3; step();
    halt_req = 0; jump_en = 0; branch_en = 0; branchFlag = 0;
    chk_all("prio_halt", 10'h020, 0, 1, 1);
    step();
    chk_all("halt_hold", 10'h020, 0, 1, 1);
    start = 1; step(); start = 0;
    chk_all("restart", 10'h000, 1, 0, 0);

    // Same-edge write and read of entry 2: branch takes the old value.
    lut_we = 1; lut_waddr = 4'd2; lut_wdata = 10'h200;
    branch_en = 1; branchFlag = 1; target_idx = 4'd2; step();
    lut_we = 0;
    chk("rbw_old", 32'(pc), 32'h100);
    step();
    branch_en = 0; branchFlag = 0;
    chk("rbw_new", 32'(pc), 32'h200);

    jump(4'd5);
    chk("pc_3ff", 32'(pc), 32'h3FF);
    step();
    chk("wrap", 32'(pc), 32'h000);

    carry_we = 1; carry_in = 1; halt_req = 1; step();
    carry_we = 0; carry_in = 0; halt_req = 0;
    chk_all("halt_carry", 10'h000, 0, 1, 1);
    start = 1; step(); start = 0;
    chk_all("restart2", 10'h000, 1, 0, 0);

    carry_we = 1; carry_in = 1; jump(4'd6);
    carry_we = 0; carry_in = 0;
    chk_all("pre_rst", 10'h055, 1, 0, 1);
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 10'h000, 0, 0, 0);
    #2 rst_n = 1'b1;
    start = 1; step(); start = 0;
    jump(4'd6);
    chk("lut_cleared", 32'(pc), 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter and control-flag stage directly downstream of the ALU.
- Consumes the ALU's branchFlag and shiftcarry_out, and produces the next instruction address.
- Holds the carry flag register that drives the ALU's shiftcarry_in.
- Implements start/done sequencing for a program run and a loadable branch-target lookup table.

Parameters:
- PC_W, 10, program counter width in bits; instruction memory depth is 2^PC_W.
- LUT_IDX_W, 4, branch-target table index width; table depth is 2^LUT_IDX_W.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a program run at address 0.
- halt_req  input  1  decoder: current instruction is HALT.
- jump_en  input  1  decoder: unconditional jump.
- branch_en  input  1  decoder: conditional branch instruction.
- branchFlag  input  1  from ALU compare result (lt/gt/eq).
- target_idx  input  LUT_IDX_W  branch/jump target table index.
- carry_we  input  1  decoder: latch ALU carry (shift/add/sub only).
- carry_in  input  1  ALU shiftcarry_out.
- carry_q  output  1  registered carry; drives ALU shiftcarry_in.
- lut_we  input  1  target table write enable.
- lut_waddr  input  LUT_IDX_W  target table write index.
- lut_wdata  input  PC_W  absolute target address.
- pc  output  PC_W  current instruction address.
- busy  output  1  high in RUN.
- done  output  1  high in HALT until the next start.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values: pc=0, carry_q=0, busy=0, done=0, state IDLE, every table entry 0. Reset mid-run aborts immediately to these values.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - pc held at 0.
  - start -> RUN; pc=0, carry_q=0.
  - All other control inputs are ignored.
- RUN:
  - busy=1.
  - Per rising edge, priority is halt_req > jump_en > (branch_en & branchFlag) > increment.
  - halt_req: -> HALT; pc holds the HALT address.
  - jump_en, or branch_en with branchFlag=1: pc <= table[target_idx] (absolute target). New pc is visible the cycle after the edge; no delay slot.
  - branch_en with branchFlag=0: pc <= pc+1.
  - Otherwise: pc <= pc+1.
  - Increment wraps from 2^PC_W-1 to 0 with no error indication.
  - start is ignored.
- HALT:
  - done=1, busy=0, pc holds.
  - start -> RUN; pc=0, carry_q=0, done=0 at the next edge.
- Carry register:
  - carry_q <= carry_in on any edge in RUN with carry_we=1; otherwise it holds.
  - carry_we is ignored in IDLE/HALT.
  - carry_we with carry_in unknown (ALU drives X on non-arith ops) is a decoder bug; the bench flags it as an error.
  - The carry write from an instruction that also asserts halt_req still commits.
- Target table:
  - Written on any edge with lut_we=1, in any state.
  - A same-edge write and read of the same index makes the branch use the old entry (read-before-write); the new value is used from the following cycle.
- branchFlag and carry_in are combinational ALU outputs sampled only at the rising edge; no same-cycle feedthrough to any output.

Decomposition:
- Shared package (cpu_pkg):
  - fetch_state_t enum {IDLE, RUN, HALT}.
  - PC_W and LUT_IDX_W defaults.
  - PC reset constant 0.
  - ALUOp encodings, so the decoder and ALU share one definition.
- One sub-module: branch_lut.
  - 2^LUT_IDX_W x PC_W register file.
  - Async clear, one synchronous write port, one combinational read port.
- FSM, pc and carry logic stay in fetch_ctrl.

Test Plan:
- Reset/sequencing: reset, then start pulse, no control inputs for 5 cycles -> pc 0,1,2,3,4,5; busy=1; done=0.
- Taken branch: table[3]=0x040, pc=0x010, branch_en=1, branchFlag=1, target_idx=3 -> next pc=0x040. Same with branchFlag=0 -> next pc=0x011.
- Priority: halt_req, jump_en and branch_en all asserted with branchFlag=1 at pc=0x020 -> state HALT, pc stays 0x020, done=1. In HALT, start pulse -> pc=0, done=0, busy=1.
- Carry register:
  - carry_we=1 with carry_in=1 at pc=5 -> carry_q=1 the next cycle.
  - carry_we=0 for 3 cycles -> carry_q stays 1.
  - Restart via start -> carry_q=0.
- Table hazard and wrap:
  - table[2]=0x100; same edge writes table[2]=0x200 and takes a branch to idx 2 -> pc=0x100; the next taken branch to idx 2 -> pc=0x200.
  - pc=0x3FF plus increment -> pc=0x000.
- Async reset mid-run: assert rst_n=0 between edges at pc=0x055 -> pc=0, busy=0, carry_q=0, table cleared immediately, without waiting for a clock edge.
